rv32_core: RTL and testbench

Single-cycle RV32I processor core with Zicsr and a minimal machine-mode trap mechanism, plus its private unified instruction/data memory. It is the top-level compute block that the riscv-tests harness (e.g. rv32si-p-csr) runs against; the harness preloads memory, releases reset and inspects `pc` and register `x3`. Pass condition: `pc == 0x44` with `rs[3] == 1`.

---
 rtl/rv32_core.sv | 224 ++++++++++++++++++++++
 tb/tb_rv32_core.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_core.sv
// Single-cycle RV32I + Zicsr core with machine-mode traps and a private 64K-word memory.
// Every instruction fetches, executes and commits at one rising edge.
module rv32_core (
  input  logic clk,
  input  logic rst
);
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0f;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  logic [31:0] pc;
  logic [31:0] rs  [0:31];
  logic [31:0] csr [0:4095];

  logic [31:0] w_inst, w_mem_rdata, w_st_word, w_addr;
  logic        w_st_en;
  logic [6:0]  w_opc;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_rs1v, w_rs2v;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [11:0] w_csr_addr;
  logic [31:0] w_csr_old, w_csr_src, w_csr_wval;
  logic        w_csr_we;
  logic [31:0] w_alu_b, w_alu, w_sra, w_ld_val;
  logic [4:0]  w_shamt;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic        w_taken, w_ld_ok;
  logic [31:0] w_next_pc, w_rd_val, w_cause, w_tval;
  logic        w_rd_we, w_trap, w_illegal, w_mret;
  logic        w_unused_addr;

  // Memory lives in a named scope so the harness can reach memory.m directly.
  if (1) begin : memory
    logic [31:0] m [0:65535];
    assign w_inst      = m[pc[17:2]];
    assign w_mem_rdata = m[w_addr[17:2]];
    always_ff @(posedge clk) begin
      if (!rst && w_st_en) m[w_addr[17:2]] <= w_st_word;
    end
  end

  assign w_opc      = w_inst[6:0];
  assign w_rd       = w_inst[11:7];
  assign w_f3       = w_inst[14:12];
  assign w_rs1      = w_inst[19:15];
  assign w_rs2      = w_inst[24:20];
  assign w_rs1v     = rs[w_rs1];
  assign w_rs2v     = rs[w_rs2];
  assign w_imm_i    = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s    = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b    = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u    = {w_inst[31:12], 12'h000};
  assign w_imm_j    = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
  assign w_csr_addr = w_inst[31:20];
  assign w_csr_old  = csr[w_csr_addr];
  assign w_csr_src  = w_f3[2] ? {27'h0, w_rs1} : w_rs1v;
  assign w_addr     = w_rs1v + ((w_opc == OP_STORE) ? w_imm_s : w_imm_i);
  assign w_unused_addr = ^w_addr[31:18];

  assign w_alu_b = (w_opc == OP_OP) ? w_rs2v : w_imm_i;
  assign w_shamt = w_alu_b[4:0];
  assign w_sra   = $signed(w_rs1v) >>> w_shamt;

  always_comb begin
    w_alu = 32'h0;
    case (w_f3)
      3'd0: w_alu = (w_opc == OP_OP && w_inst[30]) ? w_rs1v - w_alu_b : w_rs1v + w_alu_b;
      3'd1: w_alu = w_rs1v << w_shamt;
      3'd2: w_alu = {31'h0, $signed(w_rs1v) < $signed(w_alu_b)};
      3'd3: w_alu = {31'h0, w_rs1v < w_alu_b};
      3'd4: w_alu = w_rs1v ^ w_alu_b;
      3'd5: w_alu = w_inst[30] ? w_sra : w_rs1v >> w_shamt;
      3'd6: w_alu = w_rs1v | w_alu_b;
      default: w_alu = w_rs1v & w_alu_b;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'd0: w_taken = w_rs1v == w_rs2v;
      3'd1: w_taken = w_rs1v != w_rs2v;
      3'd4: w_taken = $signed(w_rs1v) < $signed(w_rs2v);
      3'd5: w_taken = $signed(w_rs1v) >= $signed(w_rs2v);
      3'd6: w_taken = w_rs1v < w_rs2v;
      3'd7: w_taken = w_rs1v >= w_rs2v;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_ld_byte = w_mem_rdata[{w_addr[1:0], 3'b000} +: 8];
  assign w_ld_half = w_addr[1] ? w_mem_rdata[31:16] : w_mem_rdata[15:0];

  always_comb begin
    w_ld_ok  = 1'b1;
    w_ld_val = w_mem_rdata;
    case (w_f3)
      3'd0: w_ld_val = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'd1: w_ld_val = {{16{w_ld_half[15]}}, w_ld_half};
      3'd2: w_ld_val = w_mem_rdata;
      3'd4: w_ld_val = {24'h0, w_ld_byte};
      3'd5: w_ld_val = {16'h0, w_ld_half};
      default: w_ld_ok = 1'b0;
    endcase
  end

  // Sub-word stores merge into the word read this cycle.
  always_comb begin
    w_st_word = w_mem_rdata;
    case (w_f3[1:0])
      2'd0:    w_st_word[{w_addr[1:0], 3'b000} +: 8] = w_rs2v[7:0];
      2'd1:    w_st_word[{w_addr[1], 4'b0000} +: 16] = w_rs2v[15:0];
      default: w_st_word = w_rs2v;
    endcase
  end

  always_comb begin
    w_next_pc  = pc + 32'd4;
    w_rd_we    = 1'b0;
    w_rd_val   = w_alu;
    w_st_en    = 1'b0;
    w_csr_we   = 1'b0;
    w_csr_wval = 32'h0;
    w_trap     = 1'b0;
    w_illegal  = 1'b0;
    w_mret     = 1'b0;
    w_cause    = 32'h0;
    w_tval     = 32'h0;
    case (w_opc)
      OP_LUI:   begin w_rd_we = 1'b1; w_rd_val = w_imm_u; end
      OP_AUIPC: begin w_rd_we = 1'b1; w_rd_val = pc + w_imm_u; end
      OP_JAL: begin
        w_rd_we = 1'b1; w_rd_val = pc + 32'd4; w_next_pc = pc + w_imm_j;
      end
      OP_JALR: begin
        if (w_f3 == 3'd0) begin
          w_rd_we = 1'b1; w_rd_val = pc + 32'd4;
          w_next_pc = (w_rs1v + w_imm_i) & ~32'd1;
        end else w_illegal = 1'b1;
      end
      OP_BRANCH: begin
        if (w_f3 == 3'd2 || w_f3 == 3'd3) w_illegal = 1'b1;
        else if (w_taken) w_next_pc = pc + w_imm_b;
      end
      OP_LOAD: begin
        if (w_ld_ok) begin w_rd_we = 1'b1; w_rd_val = w_ld_val; end
        else w_illegal = 1'b1;
      end
      OP_STORE: begin
        if (w_f3 < 3'd3) w_st_en = 1'b1;
        else w_illegal = 1'b1;
      end
      OP_IMM, OP_OP: w_rd_we = 1'b1;
      OP_FENCE: ;
      OP_SYSTEM: begin
        if (w_f3 == 3'd0) begin
          case (w_inst[31:20])
            12'h000: begin w_trap = 1'b1; w_cause = 32'd11; end
            12'h001: begin w_trap = 1'b1; w_cause = 32'd3; end
            12'h302: begin w_mret = 1'b1; w_next_pc = csr[12'h341]; end
            12'h102: w_next_pc = csr[12'h141];
            12'h105: ;
            default: w_illegal = 1'b1;
          endcase
        end else if (w_f3 == 3'd4) begin
          w_illegal = 1'b1;
        end else begin
          w_rd_we  = 1'b1;
          w_rd_val = w_csr_old;
          case (w_f3[1:0])
            2'd1:    begin w_csr_we = 1'b1; w_csr_wval = w_csr_src; end
            2'd2:    begin w_csr_we = (w_rs1 != 5'd0); w_csr_wval = w_csr_old | w_csr_src; end
            default: begin w_csr_we = (w_rs1 != 5'd0); w_csr_wval = w_csr_old & ~w_csr_src; end
          endcase
        end
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_trap = 1'b1; w_cause = 32'd2; w_tval = w_inst;
    end
    if (w_trap) begin
      w_rd_we   = 1'b0;
      w_st_en   = 1'b0;
      w_csr_we  = 1'b0;
      w_mret    = 1'b0;
      w_next_pc = {csr[12'h305][31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= 32'h0;
      for (int i = 0; i < 32; i++) rs[i] <= 32'h0;
      for (int i = 0; i < 4096; i++) csr[i] <= 32'h0;
    end else begin
      pc <= w_next_pc;
      if (w_rd_we && w_rd != 5'd0) rs[w_rd] <= w_rd_val;
      // mstatus: MIE is bit 3, MPIE is bit 7.
      if (w_trap) begin
        csr[12'h341] <= pc;
        csr[12'h342] <= w_cause;
        csr[12'h343] <= w_tval;
        csr[12'h300] <= {csr[12'h300][31:8], csr[12'h300][3], csr[12'h300][6:4], 1'b0,
                         csr[12'h300][2:0]};
      end else if (w_mret) begin
        csr[12'h300] <= {csr[12'h300][31:8], 1'b1, csr[12'h300][6:4], csr[12'h300][7],
                         csr[12'h300][2:0]};
      end else if (w_csr_we) begin
        csr[w_csr_addr] <= w_csr_wval;
      end
    end
  end
endmodule

// File: tb/tb_rv32_core.sv
// Directed programs plus random ALU operations checked against an arithmetic reference.
module tb_rv32_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  rv32_core dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    dut.memory.m[addr[17:2]] = w;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'd0, rd, 7'h13);
  endfunction

  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  // Reference ALU: op index 0..9 = add sub sll slt sltu xor srl sra or and.
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << b[4:0];
      3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4: return (a < b) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return a >> b[4:0];
      7: return sa >>> b[4:0];
      8: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic load_li(input logic [31:0] base, input logic [4:0] rd, input logic [31:0] v);
    logic [31:0] hi;
    hi = v + 32'h800;
    put(base, lui(rd, hi[31:12]));
    put(base + 32'd4, addi(rd, rd, v[11:0]));
  endtask

  initial begin
    logic [2:0] f3_tab [0:9];
    logic       alt_tab [0:9];
    f3_tab  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    alt_tab = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset release
    put(32'h0, addi(5'd3, 5'd0, 12'd1));
    put(32'h4, enc_j(21'd0, 5'd0));
    hold_reset();
    chk("reset_pc", dut.pc, 32'h0);
    chk("reset_x3", dut.rs[3], 32'h0);
    rst = 1'b0;
    step(1);
    chk("first_x3", dut.rs[3], 32'h1);
    chk("first_pc", dut.pc, 32'h4);

    // CSR read-modify-write on mscratch, then a discarded x0 write
    put(32'h00, addi(5'd5, 5'd0, 12'h0F0));
    put(32'h04, enc_i(12'h340, 5'd5, 3'd1, 5'd0, 7'h73));
    put(32'h08, enc_i(12'h340, 5'd3, 3'd6, 5'd6, 7'h73));
    put(32'h0C, enc_i(12'h340, 5'd5, 3'd3, 5'd7, 7'h73));
    put(32'h10, addi(5'd0, 5'd0, 12'd5));
    hold_reset();
    rst = 1'b0;
    step(5);
    chk("csr_x6", dut.rs[6], 32'hF0);
    chk("csr_x7", dut.rs[7], 32'hF3);
    chk("csr_mscratch", dut.csr[12'h340], 32'h03);
    chk("x0_zero", dut.rs[0], 32'h0);

    // ECALL trap and MRET
    put(32'h00, addi(5'd1, 5'd0, 12'h100));
    put(32'h04, enc_i(12'h305, 5'd1, 3'd1, 5'd0, 7'h73));
    put(32'h08, enc_j(21'h18, 5'd0));
    put(32'h20, 32'h00000073);
    put(32'h100, enc_i(12'h342, 5'd0, 3'd2, 5'd8, 7'h73));
    put(32'h104, addi(5'd9, 5'd0, 12'd5));
    put(32'h108, 32'h30200073);
    hold_reset();
    rst = 1'b0;
    step(4);
    chk("ecall_pc", dut.pc, 32'h100);
    chk("ecall_mepc", dut.csr[12'h341], 32'h20);
    chk("ecall_mcause", dut.csr[12'h342], 32'd11);
    step(3);
    chk("handler_x8", dut.rs[8], 32'd11);
    chk("handler_x9", dut.rs[9], 32'd5);
    chk("mret_pc", dut.pc, 32'h20);
    chk("mret_mstatus", dut.csr[12'h300], 32'h80);

    // Loads and stores
    put(32'h00, lui(5'd10, 20'h80FF8));
    put(32'h04, addi(5'd10, 5'd10, 12'hF01));
    put(32'h08, addi(5'd11, 5'd0, 12'h200));
    put(32'h0C, enc_s(12'd0, 5'd10, 5'd11, 3'd2));
    put(32'h10, enc_i(12'd0, 5'd11, 3'd0, 5'd12, 7'h03));
    put(32'h14, enc_i(12'd1, 5'd11, 3'd0, 5'd13, 7'h03));
    put(32'h18, enc_i(12'd2, 5'd11, 3'd0, 5'd14, 7'h03));
    put(32'h1C, enc_i(12'd3, 5'd11, 3'd0, 5'd15, 7'h03));
    put(32'h20, enc_i(12'd2, 5'd11, 3'd5, 5'd16, 7'h03));
    put(32'h24, addi(5'd17, 5'd0, 12'h0AA));
    put(32'h28, enc_s(12'd1, 5'd17, 5'd11, 3'd0));
    hold_reset();
    rst = 1'b0;
    step(11);
    chk("lb0", dut.rs[12], 32'h01);
    chk("lb1", dut.rs[13], 32'h7F);
    chk("lb2", dut.rs[14], 32'hFFFFFFFF);
    chk("lb3", dut.rs[15], 32'hFFFFFF80);
    chk("lhu2", dut.rs[16], 32'h80FF);
    chk("sb_word", dut.memory.m[16'h0080], 32'h80FFAA01);

    // Branches and JALR
    put(32'h00, addi(5'd1, 5'd0, 12'hFFF));
    put(32'h04, addi(5'd2, 5'd0, 12'd1));
    put(32'h08, enc_b(13'd8, 5'd2, 5'd1, 3'd4));
    put(32'h0C, addi(5'd20, 5'd0, 12'd7));
    put(32'h10, enc_b(13'd8, 5'd2, 5'd1, 3'd6));
    put(32'h14, addi(5'd21, 5'd0, 12'd9));
    put(32'h18, addi(5'd2, 5'd0, 12'h103));
    put(32'h1C, enc_i(12'd4, 5'd2, 3'd0, 5'd1, 7'h67));
    hold_reset();
    rst = 1'b0;
    step(3);
    chk("blt_taken_pc", dut.pc, 32'h10);
    step(1);
    chk("bltu_not_taken_pc", dut.pc, 32'h14);
    step(3);
    chk("skipped_x20", dut.rs[20], 32'h0);
    chk("fallthru_x21", dut.rs[21], 32'd9);
    chk("jalr_pc", dut.pc, 32'h106);
    chk("jalr_x1", dut.rs[1], 32'h20);

    // EBREAK and illegal instruction traps
    put(32'h00, addi(5'd1, 5'd0, 12'h040));
    put(32'h04, enc_i(12'h305, 5'd1, 3'd1, 5'd0, 7'h73));
    put(32'h08, enc_i(12'h300, 5'd8, 3'd6, 5'd0, 7'h73));
    put(32'h0C, 32'h00100073);
    put(32'h40, 32'hFFFFFFFF);
    hold_reset();
    rst = 1'b0;
    step(3);
    chk("mie_set", dut.csr[12'h300], 32'h08);
    step(1);
    chk("ebreak_mcause", dut.csr[12'h342], 32'd3);
    chk("ebreak_mepc", dut.csr[12'h341], 32'h0C);
    chk("ebreak_mtval", dut.csr[12'h343], 32'h0);
    chk("ebreak_pc", dut.pc, 32'h40);
    chk("ebreak_mstatus", dut.csr[12'h300], 32'h80);
    step(1);
    chk("illegal_mcause", dut.csr[12'h342], 32'd2);
    chk("illegal_mtval", dut.csr[12'h343], 32'hFFFFFFFF);
    chk("illegal_mepc", dut.csr[12'h341], 32'h40);
    chk("illegal_mstatus", dut.csr[12'h300], 32'h00);
    chk("illegal_x1", dut.rs[1], 32'h40);

    // Random ALU operations, register and immediate forms
    for (int it = 0; it < 40; it++) begin
      logic [31:0] a, b, exp;
      logic [11:0] imm;
      int op;
      bit itype;
      a = $urandom;
      b = $urandom;
      op = int'($urandom_range(0, 9));
      itype = bit'($urandom_range(0, 1));
      if (itype && op == 1) op = 0;
      load_li(32'h00, 5'd1, a);
      load_li(32'h08, 5'd2, b);
      if (itype) begin
        imm = 12'($urandom_range(0, 4095));
        if (op == 2 || op == 6 || op == 7) imm = {alt_tab[op] ? 7'h20 : 7'h00, imm[4:0]};
        put(32'h10, enc_i(imm, 5'd1, f3_tab[op], 5'd3, 7'h13));
        exp = ref_alu(op, a, {{20{imm[11]}}, imm});
      end else begin
        put(32'h10, enc_r(alt_tab[op] ? 7'h20 : 7'h00, 5'd2, 5'd1, f3_tab[op], 5'd3));
        exp = ref_alu(op, a, b);
      end
      hold_reset();
      rst = 1'b0;
      step(5);
      chk($sformatf("alu_op%0d_i%0d", op, itype), dut.rs[3], exp);
      chk("alu_pc", dut.pc, 32'h14);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
